uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries; power of two, 4..256.
REQ-002 SHALL have parameter AW, default 4, meaning pointer width; equals log2(DEPTH).
REQ-003 SHALL have port clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1  push wr_data this cycle.
REQ-006 SHALL have port wr_data  input  8  byte to transmit.
REQ-007 SHALL have port flush  input  1  synchronous discard of all queued bytes.
REQ-008 SHALL have port full  output  1  count == DEPTH.
REQ-009 SHALL have port empty  output  1  count == 0.
REQ-010 SHALL have port count  output  AW+1  bytes queued, excluding the byte in flight.
REQ-011 SHALL have port TxD_data  output  8  byte presented to the transmitter.
REQ-012 SHALL have port TxD_start  output  1  one-cycle start pulse to the transmitter.
REQ-013 SHALL have port TxD_busy  input  1  transmitter busy.
REQ-014 SHALL have port ovf_clr  input  1  clears overflow.
REQ-015 SHALL have port overflow  output  1  sticky push-while-full flag.

Function
REQ-016 SHALL store bytes in a circular buffer with AW-bit read/write pointers wrapping DEPTH-1 -> 0.
REQ-017 SHALL accept a push when wr_en=1 and (full=0, or a pop occurs in the same cycle); otherwise discard the byte and leave contents unchanged.
REQ-018 SHALL update count as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-019 SHALL implement FSM states IDLE, LOAD, HOLD and DRAIN.
REQ-020 SHALL transition IDLE -> LOAD when empty=0 and TxD_busy=0; on that edge it SHALL pop the head byte into the TxD_data register.
REQ-021 SHALL assert TxD_start for exactly the one cycle spent in LOAD, with TxD_data stable from LOAD until the next pop; LOAD -> HOLD unconditionally.
REQ-022 SHALL transition HOLD -> DRAIN when TxD_busy=1, or after 2 cycles in HOLD, whichever comes first (guards against a missed busy edge).
REQ-023 SHALL transition DRAIN -> IDLE when TxD_busy=0.
REQ-024 SHALL NOT issue back-to-back starts; the minimum gap between starts is 4 cycles plus the busy time.
REQ-025 SHALL give latency of 1 cycle from a push into an empty FIFO with the FSM idle and TxD_busy=0 to TxD_start=1.
REQ-026 SHALL, on flush=1, reset both pointers and count to 0 on the next edge, with flush taking priority over a simultaneous push or pop.
REQ-027 SHALL NOT abort an in-flight byte on flush: the FSM continues and TxD_data is unchanged.
REQ-028 SHALL hold TxD_start=0 while rst_n=0.

Reset
REQ-029 SHALL, when rst_n=0, asynchronously set pointers=0, count=0, state=IDLE, TxD_start=0, TxD_data=8'h00 and overflow=0, giving empty=1 and full=0.
REQ-030 SHALL, on reset mid-transmission, drop any FSM activity; after release it SHALL wait in IDLE for TxD_busy=0 before the next start.
REQ-031 SHALL NOT require storage RAM contents to be reset.

Configuration
REQ-032 SHALL, with macro UART_TX_FIFO_OVF_EN defined, set overflow to 1 on any rejected push and hold it until an ovf_clr=1 cycle; set has priority over clear in the same cycle.
REQ-033 SHALL, without UART_TX_FIFO_OVF_EN, tie overflow to constant 0, ignore ovf_clr and include no overflow register.

Verification
REQ-034 SHALL cover: push 8'h41 into empty, TxD_busy=0 -> TxD_start high exactly 1 cycle on the next cycle, TxD_data=8'h41, count returns to 0.
REQ-035 SHALL cover: push 8'h01..8'h10 (16 bytes, DEPTH=16) while TxD_busy is held 1 -> full=1, count=16, no TxD_start; release busy -> bytes emitted in order 8'h01..8'h10.
REQ-036 SHALL cover: with full=1, push 8'hFF -> byte dropped, count stays 16, overflow=1 (macro defined) or 0 (macro undefined); ovf_clr -> overflow=0.
REQ-037 SHALL cover: with count=16, simultaneous push 8'hAA and pop -> count stays 16, 8'hAA emitted last, overflow remains 0.
REQ-038 SHALL cover: flush with 5 queued bytes during DRAIN -> count=0 next cycle, in-flight TxD_data unchanged, no further TxD_start.
REQ-039 SHALL cover: assert rst_n=0 during HOLD -> TxD_start=0, empty=1 immediately; after release with TxD_busy=1 -> no start until busy falls and a new byte is pushed.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter through a start/busy handshake.
// Define UART_TX_FIFO_OVF_EN to build the sticky overflow flag; otherwise overflow is tied to 0.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [7:0]    TxD_data,
  output logic          TxD_start,
  input  logic          TxD_busy,
  input  logic          ovf_clr,
  output logic          overflow
);

  if (DEPTH != (1 << AW) || DEPTH < 4 || DEPTH > 256) begin : g_bad_param
    $error("uart_tx_fifo: DEPTH must equal 2**AW and lie in 4..256");
  end

  typedef enum logic [1:0] {StIdle, StLoad, StHold, StDrain} state_e;

  localparam logic [AW-1:0] LP_PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LP_CNT_ONE = {{AW{1'b0}}, 1'b1};

  state_e        r_state;
  state_e        w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_txd_data;
  logic          r_hold_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_pop_req;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_push;

  // count never exceeds DEPTH == 2**AW, so its MSB alone marks a full buffer
  assign w_full  = r_count[AW];
  assign w_empty = (r_count == '0);

  // The FSM pulls the head byte only from IDLE with the transmitter free.
  assign w_pop_req = (r_state == StIdle) && !w_empty && !TxD_busy;
  assign w_pop     = w_pop_req && !flush;

  // A full buffer still takes a byte when the head leaves on the same edge.
  assign w_push_ok = wr_en && (!w_full || w_pop_req);
  assign w_push    = w_push_ok && !flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Holds the byte in flight; flush leaves it alone so the current frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txd_data <= 8'h00;
    end else if (w_pop) begin
      r_txd_data <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= 1'b0;
    end else begin
      r_hold_cnt <= (r_state == StHold);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // HOLD leaves after two cycles even without busy, in case the busy edge was missed.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_pop) w_state_nxt = StLoad;
      StLoad:  w_state_nxt = StHold;
      StHold:  if (TxD_busy || r_hold_cnt) w_state_nxt = StDrain;
      StDrain: if (!TxD_busy) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    TxD_start = 1'b0;
    if (r_state == StLoad) begin
      TxD_start = 1'b1;
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic r_overflow;
  logic w_push_rej;

  assign w_push_rej = wr_en && !w_push_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_push_rej) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;
`else
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = ovf_clr;
  assign overflow         = 1'b0;
`endif

  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign TxD_data = r_txd_data;

  a_start_single: assert property (@(posedge clk) disable iff (!rst_n)
    TxD_start |=> !TxD_start);

  a_full_empty_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_full && w_empty));

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_count[AW] && (|r_count[AW-1:0])));

  a_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
    !w_pop |=> $stable(r_txd_data));

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH=16); overflow expectations follow
// whether UART_TX_FIFO_OVF_EN is defined for the build.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          wr_en    = 1'b0;
  logic [7:0]    wr_data  = 8'h00;
  logic          flush    = 1'b0;
  logic          TxD_busy = 1'b0;
  logic          ovf_clr  = 1'b0;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic [7:0]    TxD_data;
  logic          TxD_start;
  logic          overflow;

  int            n_checks = 0;
  int            n_errors = 0;
  int            start_cnt = 0;
  logic [7:0]    sent_q[$];
  logic          prev_start = 1'b0;
  logic          b2b_seen = 1'b0;
  logic          exp_ovf;

  always #10 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .flush     (flush),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .TxD_data  (TxD_data),
    .TxD_start (TxD_start),
    .TxD_busy  (TxD_busy),
    .ovf_clr   (ovf_clr),
    .overflow  (overflow)
  );

  // Record every start pulse and the byte presented with it.
  always @(negedge clk) begin
    if (TxD_start) begin
      start_cnt = start_cnt + 1;
      sent_q.push_back(TxD_data);
      if (prev_start) b2b_seen = 1'b1;
    end
    prev_start = TxD_start;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    tick(1);
    wr_en   = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (start_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    ok = (start_cnt >= target);
  endtask

  task automatic test_reset;
    tick(2);
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (TxD_start !== 1'b0) begin n_errors++; $display("FAIL reset_start: got %b want 0", TxD_start); end
    n_checks++; if (TxD_data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h want 00", TxD_data); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_single_byte;
    int base;
    base = start_cnt;
    TxD_busy = 1'b0;
    push(8'h41);
    n_checks++; if (count !== 5'd1) begin n_errors++; $display("FAIL single_count_after_push: got %0d want 1", count); end
    n_checks++; if (TxD_start !== 1'b0) begin n_errors++; $display("FAIL single_start_early: got %b want 0", TxD_start); end
    tick(1);
    n_checks++; if (TxD_start !== 1'b1) begin n_errors++; $display("FAIL single_start: got %b want 1", TxD_start); end
    n_checks++; if (TxD_data !== 8'h41) begin n_errors++; $display("FAIL single_data: got %h want 41", TxD_data); end
    n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL single_count_after_pop: got %0d want 0", count); end
    tick(1);
    n_checks++; if (TxD_start !== 1'b0) begin n_errors++; $display("FAIL single_start_width: got %b want 0", TxD_start); end
    n_checks++; if (TxD_data !== 8'h41) begin n_errors++; $display("FAIL single_data_hold: got %h want 41", TxD_data); end
    tick(6);
    n_checks++; if (start_cnt !== base + 1) begin n_errors++; $display("FAIL single_start_count: got %0d want %0d", start_cnt, base + 1); end
  endtask

  task automatic test_fill_order;
    int base;
    bit ok;
    base = start_cnt;
    TxD_busy = 1'b1;
    tick(1);
    for (int i = 0; i < 16; i++) push(8'(i + 1));
    n_checks++; if (full !== 1'b1) begin n_errors++; $display("FAIL fill_full: got %b want 1", full); end
    n_checks++; if (count !== 5'd16) begin n_errors++; $display("FAIL fill_count: got %0d want 16", count); end
    n_checks++; if (start_cnt !== base) begin n_errors++; $display("FAIL fill_no_start: got %0d starts want %0d", start_cnt, base); end
    TxD_busy = 1'b0;
    wait_starts(base + 16, 200, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL fill_drain_timeout: got %0d starts want %0d", start_cnt, base + 16); end
    tick(6);
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (sent_q[base + i] !== 8'(i + 1)) begin
        n_errors++; $display("FAIL fill_order[%0d]: got %h want %h", i, sent_q[base + i], 8'(i + 1));
      end
    end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL fill_empty_after: got %b want 1", empty); end
  endtask

  task automatic test_overflow;
    TxD_busy = 1'b1;
    tick(1);
    for (int i = 0; i < 16; i++) push(8'(8'h21 + i));
    push(8'hFF);
    n_checks++; if (count !== 5'd16) begin n_errors++; $display("FAIL ovf_count: got %0d want 16", count); end
    n_checks++; if (overflow !== exp_ovf) begin n_errors++; $display("FAIL ovf_set: got %b want %b", overflow, exp_ovf); end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    // Set wins over clear in the same cycle.
    ovf_clr = 1'b1;
    push(8'hFF);
    ovf_clr = 1'b0;
    n_checks++; if (overflow !== exp_ovf) begin n_errors++; $display("FAIL ovf_set_prio: got %b want %b", overflow, exp_ovf); end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear2: got %b want 0", overflow); end
  endtask

  task automatic test_push_pop_full;
    int base;
    bit ok;
    base = start_cnt;
    TxD_busy = 1'b0;
    push(8'hAA);
    n_checks++; if (count !== 5'd16) begin n_errors++; $display("FAIL pp_count: got %0d want 16", count); end
    n_checks++; if (TxD_start !== 1'b1) begin n_errors++; $display("FAIL pp_start: got %b want 1", TxD_start); end
    n_checks++; if (TxD_data !== 8'h21) begin n_errors++; $display("FAIL pp_data: got %h want 21", TxD_data); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL pp_ovf: got %b want 0", overflow); end
    wait_starts(base + 17, 300, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL pp_drain_timeout: got %0d starts want %0d", start_cnt, base + 17); end
    tick(6);
    n_checks++; if (sent_q[base + 15] !== 8'h30) begin n_errors++; $display("FAIL pp_second_last: got %h want 30", sent_q[base + 15]); end
    n_checks++; if (sent_q[base + 16] !== 8'hAA) begin n_errors++; $display("FAIL pp_last: got %h want AA", sent_q[base + 16]); end
    n_checks++; if (start_cnt !== base + 17) begin n_errors++; $display("FAIL pp_start_count: got %0d want %0d", start_cnt, base + 17); end
    n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL pp_count_end: got %0d want 0", count); end
  endtask

  task automatic test_flush_drain;
    int base;
    base = start_cnt;
    TxD_busy = 1'b1;
    tick(1);
    for (int i = 0; i < 6; i++) push(8'(8'h51 + i));
    TxD_busy = 1'b0;
    tick(1);
    n_checks++; if (TxD_start !== 1'b1) begin n_errors++; $display("FAIL flush_start: got %b want 1", TxD_start); end
    n_checks++; if (count !== 5'd5) begin n_errors++; $display("FAIL flush_queued: got %0d want 5", count); end
    TxD_busy = 1'b1;
    tick(2);
    // Flush wins over a push in the same cycle.
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h99;
    tick(1);
    flush = 1'b0;
    wr_en = 1'b0;
    n_checks++; if (count !== 5'd0) begin n_errors++; $display("FAIL flush_count: got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL flush_empty: got %b want 1", empty); end
    n_checks++; if (TxD_data !== 8'h51) begin n_errors++; $display("FAIL flush_inflight: got %h want 51", TxD_data); end
    tick(3);
    TxD_busy = 1'b0;
    tick(15);
    n_checks++; if (start_cnt !== base + 1) begin n_errors++; $display("FAIL flush_no_more_start: got %0d want %0d", start_cnt, base + 1); end
    n_checks++; if (TxD_data !== 8'h51) begin n_errors++; $display("FAIL flush_data_kept: got %h want 51", TxD_data); end
  endtask

  task automatic test_reset_hold;
    int base;
    base = start_cnt;
    TxD_busy = 1'b1;
    tick(1);
    push(8'h61);
    push(8'h62);
    TxD_busy = 1'b0;
    tick(1);
    n_checks++; if (TxD_data !== 8'h61) begin n_errors++; $display("FAIL rh_load_data: got %h want 61", TxD_data); end
    tick(1);
    n_checks++; if (count !== 5'd1) begin n_errors++; $display("FAIL rh_hold_count: got %0d want 1", count); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (TxD_start !== 1'b0) begin n_errors++; $display("FAIL rh_start: got %b want 0", TxD_start); end
    n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL rh_empty: got %b want 1", empty); end
    n_checks++; if (TxD_data !== 8'h00) begin n_errors++; $display("FAIL rh_data: got %h want 00", TxD_data); end
    TxD_busy = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    push(8'h77);
    tick(4);
    n_checks++; if (start_cnt !== base + 1) begin n_errors++; $display("FAIL rh_wait_busy: got %0d want %0d", start_cnt, base + 1); end
    n_checks++; if (count !== 5'd1) begin n_errors++; $display("FAIL rh_count: got %0d want 1", count); end
    TxD_busy = 1'b0;
    tick(1);
    n_checks++; if (TxD_start !== 1'b1) begin n_errors++; $display("FAIL rh_restart: got %b want 1", TxD_start); end
    n_checks++; if (TxD_data !== 8'h77) begin n_errors++; $display("FAIL rh_restart_data: got %h want 77", TxD_data); end
    tick(6);
    n_checks++; if (b2b_seen !== 1'b0) begin n_errors++; $display("FAIL b2b_start: got %b want 0", b2b_seen); end
  endtask

  initial begin
`ifdef UART_TX_FIFO_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    test_reset;
    test_single_byte;
    test_fill_order;
    test_overflow;
    test_push_pop_full;
    test_flush_drain;
    test_reset_hold;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
